// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch core.
// Contents: seconds-field limits, default-width {min,sec} time record,
// and the count-direction enum used by the time counter.
package stopwatch_pkg;

  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned SEC_W     = 6;
  // Default minute width; the top re-derives the record for its own MIN_W.
  localparam int unsigned MIN_W_DEF = 6;

  typedef struct packed {
    logic [MIN_W_DEF-1:0] min;
    logic [SEC_W-1:0]     sec;
  } time_rec_t;

  typedef enum logic {
    DirUp,
    DirDown
  } count_dir_e;

endpackage

// File: rtl/lap_fifo.sv
// Circular buffer of lap time records with overwrite-on-full.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write data into the tail; when full the oldest entry is dropped
//   pop        drop the head entry; ignored when empty
//   data       record to push
//   head       oldest unread record, 0 when empty (combinational from storage)
//   count      number of stored entries
module lap_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 12,
  localparam int unsigned AW   = $clog2(Depth),
  localparam int unsigned CntW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [DataW-1:0] data,
  output logic [DataW-1:0] head,
  output logic [CntW-1:0]  count
);

  logic [DataW-1:0] mem_q [Depth];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_pop;

  assign full   = (count_q == CntW'(Depth));
  assign do_pop = pop && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      // When full, wr_ptr == rd_ptr, so the write lands on the oldest entry;
      // advancing rd_ptr drops it. A simultaneous pop consumes the same slot.
      if (do_pop || full) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS stopwatch core with run/pause, manual adjust and a lap-capture FIFO.
// Optional count-down is built only when LAP_STOPWATCH_COUNTDOWN_EN is defined;
// otherwise count_down is ignored and expired is tied to 0.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   tick_1hz, tick_adj    one-cycle count / adjust enables
//   start_stop            toggles running (ignored while adj=1)
//   lap, lap_rd           capture current time (when running) / pop FIFO head
//   adj, sel, count_down  adjust mode, adjust target (0 min, 1 sec), direction
//   min, sec, running     live time and run state
//   expired               sticky count-down-reached-zero flag
//   lap_min, lap_sec      oldest unread lap, 0 when empty
//   lap_valid, lap_count  FIFO non-empty, FIFO occupancy
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN   = 59,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MIN_W     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_1hz,
  input  logic                       tick_adj,
  input  logic                       start_stop,
  input  logic                       lap,
  input  logic                       lap_rd,
  input  logic                       adj,
  input  logic                       sel,
  input  logic                       count_down,
  output logic [MIN_W-1:0]           min,
  output logic [SEC_W-1:0]           sec,
  output logic                       running,
  output logic                       expired,
  output logic [MIN_W-1:0]           lap_min,
  output logic [SEC_W-1:0]           lap_sec,
  output logic                       lap_valid,
  output logic [$clog2(LAP_DEPTH):0] lap_count
);

  localparam logic [MIN_W-1:0] MinMax = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SecMax = SEC_W'(SEC_MAX);

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } rec_t;

  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             running_q, running_d;
  rec_t             cur_rec, head_rec;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  logic       expired_q, expired_d;
  count_dir_e dir;
  assign dir = count_down ? DirDown : DirUp;
`else
  logic unused_count_down;
  assign unused_count_down = count_down;
`endif

  always_comb begin
    min_d     = min_q;
    sec_d     = sec_q;
    running_d = running_q;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    expired_d = expired_q;
`endif
    if (adj) begin
      // Adjust never carries between fields; running holds.
      if (tick_adj) begin
        if (sel) begin
          sec_d = (sec_q == SecMax) ? '0 : sec_q + 1'b1;
        end else begin
          min_d = (min_q == MinMax) ? '0 : min_q + 1'b1;
        end
      end
    end else begin
      if (tick_1hz && running_q) begin
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
        if (dir == DirDown) begin
          if (min_q == '0 && sec_q == '0) begin
            // Restarted at 00:00: expire again without moving.
            running_d = 1'b0;
            expired_d = 1'b1;
          end else begin
            if (sec_q == '0) begin
              sec_d = SecMax;
              min_d = min_q - 1'b1;
            end else begin
              sec_d = sec_q - 1'b1;
            end
            if (min_q == '0 && sec_q == SEC_W'(1)) begin
              running_d = 1'b0;
              expired_d = 1'b1;
            end
          end
        end else
`endif
        begin
          if (sec_q == SecMax) begin
            sec_d = '0;
            min_d = (min_q == MinMax) ? '0 : min_q + 1'b1;
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
      end
      if (start_stop) begin
        running_d = ~running_q;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
        if (!running_q) begin
          expired_d = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
      expired_q <= 1'b0;
`endif
    end else begin
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
      expired_q <= expired_d;
`endif
    end
  end

  // Captures the registered (pre-tick) time.
  assign cur_rec.min = min_q;
  assign cur_rec.sec = sec_q;

  lap_fifo #(
    .Depth (LAP_DEPTH),
    .DataW (MIN_W + SEC_W)
  ) u_lap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lap && running_q),
    .pop   (lap_rd),
    .data  (cur_rec),
    .head  (head_rec),
    .count (lap_count)
  );

  assign min       = min_q;
  assign sec       = sec_q;
  assign running   = running_q;
  assign lap_min   = head_rec.min;
  assign lap_sec   = head_rec.sec;
  assign lap_valid = (lap_count != '0);

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  assign expired = expired_q;
`else
  assign expired = 1'b0;
`endif

endmodule
